// File: rtl/r7_uart_tx_if.sv
// rtl/r7_uart_tx_if.sv - R7 capture inputs and UART status outputs for r7_uart_tx
// The core side drives r7_data/enable; the serial port returns line and queue status.
interface r7_uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [15:0]                 r7_data;
  logic                        enable;
  logic                        tx;
  logic                        busy;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output r7_data, enable,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  r7_data, enable,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/r7_uart_tx.sv
// rtl/r7_uart_tx.sv - queues every change of R7 and sends each word as two 8N1 bytes
// High byte first; one IDLE pop cycle separates consecutive words.
module r7_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  r7_uart_tx_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [15:0]   r7_prev_q;
  logic [15:0]   hold_q;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          tx_q;
  logic          byte_sel_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;

  logic          push_req, pop, full, push_ok, timer_done;
  logic [7:0]    cur_byte;

  assign push_req   = bus.enable && (bus.r7_data != r7_prev_q);
  // Pop only looks at the registered count, so an empty FIFO is never bypassed.
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign full       = (count_q == FULL);
  assign push_ok    = push_req && (!full || pop);
  assign cur_byte   = byte_sel_q ? hold_q[15:8] : hold_q[7:0];
  assign timer_done = (timer_q == T_LAST);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (push_req && !push_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r7_prev_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      r7_prev_q  <= bus.r7_data;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.r7_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      hold_q     <= '0;
      byte_sel_q <= 1'b0;
      timer_q    <= '0;
      bit_idx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q    <= 1'b1;
          timer_q <= '0;
          if (pop) begin
            hold_q     <= mem_q[rd_ptr_q];
            byte_sel_q <= 1'b1;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (timer_done) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (timer_done) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STOP: begin
          if (timer_done) begin
            timer_q <= '0;
            if (byte_sel_q) begin
              // Low byte follows immediately, no idle gap inside a word.
              byte_sel_q <= 1'b0;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE) || (count_q != '0);
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_r7_uart_tx.sv
// tb/tb_r7_uart_tx.sv - directed self-checking bench for r7_uart_tx
// CLKS_PER_BIT=4, FIFO_DEPTH=4; outputs sampled on the falling clock edge.
module tb_r7_uart_tx;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  r7_uart_tx_if #(.FIFO_DEPTH(4)) bus ();

  r7_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic        exp_frame;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Polls tx on falling edges; returns at the first low sample (frame cycle 0).
  task automatic wait_fall(input int bound, output logic found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (bus.tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Called at frame cycle 0; samples mid-bit and ends at frame cycle 78.
  task automatic rx_frame(output logic [15:0] w, output logic ok);
    logic b;
    ok = 1'b1;
    w  = '0;
    for (int i = 0; i < 20; i++) begin
      repeat ((i == 0) ? 2 : 4) @(negedge clock);
      b = bus.tx;
      if (i == 0 || i == 10)      ok = ok && (b === 1'b0);
      else if (i == 9 || i == 19) ok = ok && (b === 1'b1);
      else if (i < 9)             w[8 + i - 1] = b;
      else                        w[i - 11] = b;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic        found;
    logic        ok;
    logic [15:0] w;
    int          viol;
    logic [15:0] exp_full [6];

    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.r7_data = 16'h0000;
    bus.enable  = 1'b1;

    vecs[0] = '{1'b1, 16'h0000, 1'b1, 16'h0000};
    vecs[1] = '{1'b1, 16'h00FF, 1'b1, 16'h00FF};
    vecs[2] = '{1'b0, 16'h1234, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 16'h1234, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 16'h1235, 1'b1, 16'h1235};
    vecs[5] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[6] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 16'h8001, 1'b1, 16'h8001};

    exp_full = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};

    // Reset state and quiet line
    repeat (3) @(negedge clock);
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_ovf", bus.overflow, 0);
    reset = 1'b1;
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_count !== 3'd0) viol++;
    end
    chk("quiet_violations", viol, 0);

    // Single word with exact latency
    @(posedge clock); #1;
    bus.r7_data = 16'hA55A;
    @(negedge clock);
    chk("single_pre_tx", bus.tx, 1);
    chk("single_pre_count", bus.fifo_count, 0);
    @(negedge clock);
    chk("single_push_count", bus.fifo_count, 1);
    chk("single_push_tx", bus.tx, 1);
    chk("single_push_busy", bus.busy, 1);
    @(negedge clock);
    chk("single_fall_tx", bus.tx, 0);
    chk("single_pop_count", bus.fifo_count, 0);
    rx_frame(w, ok);
    chk("single_word", w, 16'hA55A);
    chk("single_framing", ok, 1);
    @(negedge clock);
    chk("single_busy_79", bus.busy, 1);
    @(negedge clock);
    chk("single_busy_80", bus.busy, 0);

    // Table of single-word vectors
    for (int v = 0; v < 8; v++) begin
      repeat (3) @(negedge clock);
      @(posedge clock); #1;
      bus.enable  = vecs[v].en;
      bus.r7_data = vecs[v].data;
      if (vecs[v].exp_frame) begin
        wait_fall(10, found);
        chk($sformatf("vec%0d_fall", v), found, 1);
        if (found) begin
          rx_frame(w, ok);
          chk($sformatf("vec%0d_word", v), w, vecs[v].exp_word);
          chk($sformatf("vec%0d_framing", v), ok, 1);
          repeat (2) @(negedge clock);
          chk($sformatf("vec%0d_idle_busy", v), bus.busy, 0);
        end
      end else begin
        wait_fall(40, found);
        chk($sformatf("vec%0d_no_frame", v), found, 0);
        chk($sformatf("vec%0d_count", v), bus.fifo_count, 0);
      end
    end

    // Burst of six changes: 1..5 sent, 6 dropped with overflow
    repeat (3) @(negedge clock);
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          @(posedge clock); #1;
          bus.r7_data = 16'(k);
        end
        @(negedge clock);
        chk("burst_ovf_before", bus.overflow, 0);
        chk("burst_count_full", bus.fifo_count, 4);
        @(negedge clock);
        chk("burst_ovf_after", bus.overflow, 1);
        chk("burst_count_hold", bus.fifo_count, 4);
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          wait_fall(300, found);
          chk($sformatf("burst%0d_fall", k), found, 1);
          if (found) begin
            rx_frame(w, ok);
            chk($sformatf("burst%0d_word", k), w, 16'(k));
            chk($sformatf("burst%0d_framing", k), ok, 1);
          end
        end
      end
    join
    wait_fall(120, found);
    chk("burst_no_sixth", found, 0);
    chk("burst_ovf_sticky", bus.overflow, 1);
    chk("burst_idle_busy", bus.busy, 0);

    bus.enable  = 1'b0;
    bus.r7_data = 16'h0000;
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    chk("ovf_clear_by_reset", bus.overflow, 0);
    @(negedge clock);
    reset = 1'b1;
    bus.enable = 1'b1;
    repeat (3) @(negedge clock);

    // Reset during bit 3 of the high byte with two words queued
    @(posedge clock); #1;
    bus.r7_data = 16'h0011;
    @(posedge clock); #1;
    bus.r7_data = 16'h0022;
    @(posedge clock); #1;
    bus.r7_data = 16'h0000;
    @(negedge clock);
    chk("rstmid_fall", bus.tx, 0);
    @(negedge clock);
    chk("rstmid_queued", bus.fifo_count, 2);
    repeat (16) @(negedge clock);
    chk("rstmid_bit3", bus.tx, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_tx", bus.tx, 1);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_count", bus.fifo_count, 0);
    chk("rstmid_ovf", bus.overflow, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_fall(150, found);
    chk("rstmid_no_residual", found, 0);
    chk("rstmid_post_count", bus.fifo_count, 0);

    // Full FIFO with push in the IDLE pop cycle
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          @(posedge clock); #1;
          bus.r7_data = exp_full[k-1];
        end
        repeat (78) @(posedge clock);
        #1;
        bus.r7_data = 16'h0606;
        @(negedge clock);
        chk("full_idle_count", bus.fifo_count, 4);
        chk("full_idle_tx", bus.tx, 1);
        @(negedge clock);
        chk("full_pushpop_count", bus.fifo_count, 4);
        chk("full_pushpop_ovf", bus.overflow, 0);
        chk("full_pushpop_tx", bus.tx, 0);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          wait_fall(200, found);
          chk($sformatf("full%0d_fall", k), found, 1);
          if (found) begin
            rx_frame(w, ok);
            chk($sformatf("full%0d_word", k), w, exp_full[k]);
            chk($sformatf("full%0d_framing", k), ok, 1);
          end
        end
      end
    join
    repeat (4) @(negedge clock);
    chk("full_end_busy", bus.busy, 0);
    chk("full_end_ovf", bus.overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
